// File: rtl/alu_result_stage.sv
// Two-entry result buffer behind the ALU: holds {sel, result, flags} per entry,
// tracks sticky carry/overflow/flag-consistency status and a saturating accept count.
module alu_result_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_sel,
  input  logic [7:0]       in_result,
  input  logic             in_carry,
  input  logic             in_zero,
  input  logic             in_negative,
  input  logic             in_overflow,
  input  logic             in_parity,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_result,
  output logic [2:0]       out_sel,
  output logic [4:0]       out_flags,
  input  logic             clr_sticky,
  output logic             sticky_carry,
  output logic             sticky_ovf,
  output logic             flag_err,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] CNT_EMPTY = 2'd0;
  localparam logic [1:0] CNT_FULL  = 2'd2;

  // Zero must mirror (result == 0) and negative must mirror the result sign bit.
  function automatic logic flags_inconsistent(input logic [7:0] res, input logic z, input logic n);
    return (z != (res == 8'h00)) || (n != res[7]);
  endfunction

  logic [15:0]      r_mem [2];
  logic [1:0]       r_count;
  logic             r_wptr;
  logic             r_rptr;
  logic [15:0]      r_head;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_sticky_carry;
  logic             r_sticky_ovf;
  logic             r_flag_err;
  logic [CNT_W-1:0] r_op_count;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_nxt;
  logic             w_rptr_nxt;
  logic [15:0]      w_in_entry;
  logic [15:0]      w_head_nxt;
  logic             w_sticky_carry_nxt;
  logic             w_sticky_ovf_nxt;
  logic             w_flag_err_nxt;
  logic [CNT_W-1:0] w_op_count_nxt;

  // Handshake decode, occupancy/pointer next state and the next head entry.
  always_comb begin
    w_push      = in_valid && r_in_ready;
    w_pop       = r_out_valid && out_ready;
    w_in_entry  = {in_sel, in_result, in_carry, in_zero, in_negative, in_overflow, in_parity};
    w_count_nxt = r_count;
    w_rptr_nxt  = r_rptr;
    w_head_nxt  = r_head;

    case ({w_push, w_pop})
      2'b10: begin
        w_count_nxt = r_count + 2'd1;
      end
      2'b01: begin
        w_count_nxt = r_count - 2'd1;
        w_rptr_nxt  = ~r_rptr;
      end
      2'b11: begin
        w_count_nxt = r_count;
        w_rptr_nxt  = ~r_rptr;
      end
      default: begin
        w_count_nxt = r_count;
      end
    endcase

    // The head register keeps its last value while empty; a slot being written this cycle comes from the input.
    if (w_count_nxt == CNT_EMPTY) begin
      w_head_nxt = r_head;
    end else if (w_push && (r_wptr == w_rptr_nxt)) begin
      w_head_nxt = w_in_entry;
    end else begin
      w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

  // Sticky status (a setting push wins over a clear) and the saturating accept counter.
  always_comb begin
    w_sticky_carry_nxt = (clr_sticky ? 1'b0 : r_sticky_carry) | (w_push && in_carry);
    w_sticky_ovf_nxt   = (clr_sticky ? 1'b0 : r_sticky_ovf)   | (w_push && in_overflow);
    w_flag_err_nxt     = (clr_sticky ? 1'b0 : r_flag_err)     |
                         (w_push && flags_inconsistent(in_result, in_zero, in_negative));
    if (w_push && (r_op_count != {CNT_W{1'b1}})) begin
      w_op_count_nxt = r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      w_op_count_nxt = r_op_count;
    end
  end

  // State registers; ready/valid are registered from next occupancy so neither depends combinationally on the handshake inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0]       <= 16'h0000;
      r_mem[1]       <= 16'h0000;
      r_count        <= CNT_EMPTY;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_head         <= 16'h0000;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_sticky_carry <= 1'b0;
      r_sticky_ovf   <= 1'b0;
      r_flag_err     <= 1'b0;
      r_op_count     <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_in_entry;
        r_wptr        <= ~r_wptr;
      end
      r_count        <= w_count_nxt;
      r_rptr         <= w_rptr_nxt;
      r_head         <= w_head_nxt;
      r_in_ready     <= (w_count_nxt != CNT_FULL);
      r_out_valid    <= (w_count_nxt != CNT_EMPTY);
      r_sticky_carry <= w_sticky_carry_nxt;
      r_sticky_ovf   <= w_sticky_ovf_nxt;
      r_flag_err     <= w_flag_err_nxt;
      r_op_count     <= w_op_count_nxt;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_sel      = r_head[15:13];
  assign out_result   = r_head[12:5];
  assign out_flags    = r_head[4:0];
  assign sticky_carry = r_sticky_carry;
  assign sticky_ovf   = r_sticky_ovf;
  assign flag_err     = r_flag_err;
  assign op_count     = r_op_count;

endmodule
